// File: rtl/palette_update_ctrl.sv
// Palette RAM write scheduler: queues CPU palette writes and commits them only
// during blanking; also runs a blanking-only full-palette clear to black.
//
// state | meaning
// IDLE  | commit queued writes while videoOn is low; hold one cycle when a clear is pending
// CLEAR | write black to entry cnt on each blanking cycle, cnt = 0..ENTRIES-1
module palette_update_ctrl #(
    parameter int ENTRIES = 18,
    parameter int IDX_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic             vgaClk,
    input  logic             rst,
    input  logic             videoOn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [23:0]      wr_rgb,
    input  logic             clear_req,
    output logic             pal_we,
    output logic [IDX_W-1:0] pal_addr,
    output logic [23:0]      pal_wdata,
    output logic             busy,
    output logic             err_oob
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_d;
    logic             clear_pend, clear_pend_d;
    logic [IDX_W-1:0] cnt, cnt_d;

    logic [IDX_W-1:0] mem_idx [DEPTH];
    logic [23:0]      mem_rgb [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;

    logic             full, empty, accept, oob, push, pop, clear_take;
    logic             pal_we_d;
    logic [IDX_W-1:0] pal_addr_d;
    logic [23:0]      pal_wdata_d;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign wr_ready   = !full && !clear_pend && (state == IDLE);
    assign accept     = wr_valid && wr_ready;
    assign oob        = (wr_index >= NUM_IDX);
    assign clear_take = clear_req && !clear_pend && (state == IDLE);
    // A clear on the same edge discards the incoming write along with the queue.
    assign push       = accept && !oob && !clear_req;
    assign pop        = (state == IDLE) && !clear_pend && !videoOn && !empty;
    assign busy       = clear_pend || (state == CLEAR) || !empty;

    always_comb begin
        state_d      = state;
        clear_pend_d = clear_pend;
        cnt_d        = cnt;
        pal_we_d     = 1'b0;
        pal_addr_d   = pal_addr;
        pal_wdata_d  = pal_wdata;
        case (state)
            IDLE: begin
                if (pop) begin
                    pal_we_d    = 1'b1;
                    pal_addr_d  = mem_idx[rptr];
                    pal_wdata_d = mem_rgb[rptr];
                end
                if (clear_pend) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (clear_take) begin
                    clear_pend_d = 1'b1;
                end
            end
            CLEAR: begin
                if (!videoOn) begin
                    pal_we_d    = 1'b1;
                    pal_addr_d  = cnt;
                    pal_wdata_d = 24'h000000;
                    cnt_d       = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_d      = IDLE;
                        clear_pend_d = 1'b0;
                        cnt_d        = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vgaClk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            cnt        <= '0;
            pal_we     <= 1'b0;
            pal_addr   <= '0;
            pal_wdata  <= '0;
            err_oob    <= 1'b0;
        end else begin
            state      <= state_d;
            clear_pend <= clear_pend_d;
            cnt        <= cnt_d;
            pal_we     <= pal_we_d;
            pal_addr   <= pal_addr_d;
            pal_wdata  <= pal_wdata_d;
            err_oob    <= accept && oob;
        end
    end

    always_ff @(posedge vgaClk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear_take) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge vgaClk) begin
        if (push) begin
            mem_idx[wptr] <= wr_index;
            mem_rgb[wptr] <= wr_rgb;
        end
    end

endmodule

// File: tb/tb_palette_update_ctrl.sv
// Self-checking bench for palette_update_ctrl: directed scenarios then random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_palette_update_ctrl;

    localparam int ENTRIES = 18;
    localparam int IDX_W   = 8;
    localparam int DEPTH   = 4;

    logic        vgaClk = 1'b0;
    logic        rst, videoOn, wr_valid, wr_ready, clear_req;
    logic        pal_we, busy, err_oob;
    logic [7:0]  wr_index, pal_addr;
    logic [23:0] wr_rgb, pal_wdata;

    int tests = 0;
    int fails = 0;

    // Reference model: pending writes as a queue of {index, rgb}; a clear is
    // either waiting to start (m_pend) or walking addresses (m_clearing).
    logic [31:0] q[$];
    bit          m_pend, m_clearing;
    int          m_next;
    bit          e_we, e_err;
    logic [7:0]  e_addr;
    logic [23:0] e_data;

    always #5 vgaClk = ~vgaClk;

    palette_update_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .vgaClk(vgaClk), .rst(rst), .videoOn(videoOn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .clear_req(clear_req), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .busy(busy), .err_oob(err_oob)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (q.size() < DEPTH) && !m_pend && !m_clearing;
    endfunction

    function automatic bit model_busy();
        return m_pend || m_clearing || (q.size() != 0);
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_clearing = 0; m_next = 0;
        e_we = 0; e_err = 0; e_addr = 8'h00; e_data = 24'h0;
    endtask

    task automatic model_edge();
        bit          acc, clr_busy;
        logic [31:0] head;
        acc      = wr_valid && model_ready();
        clr_busy = m_pend || m_clearing;
        e_err    = acc && (int'(wr_index) >= ENTRIES);
        e_we     = 0;
        if (m_clearing) begin
            if (!videoOn) begin
                e_we = 1; e_addr = 8'(m_next); e_data = 24'h0;
                m_next++;
                if (m_next == ENTRIES) m_clearing = 0;
            end
        end else if (m_pend) begin
            m_pend = 0; m_clearing = 1; m_next = 0;
        end else if (!videoOn && q.size() > 0) begin
            head = q.pop_front();
            e_we = 1; e_addr = head[31:24]; e_data = head[23:0];
        end
        if (acc && int'(wr_index) < ENTRIES && !clear_req) q.push_back({wr_index, wr_rgb});
        if (clear_req && !clr_busy) begin
            q.delete();
            m_pend = 1;
        end
    endtask

    task automatic check_regs();
        check("pal_we", 32'(pal_we), 32'(e_we));
        check("pal_addr", 32'(pal_addr), 32'(e_addr));
        check("pal_wdata", 32'(pal_wdata), 32'(e_data));
        check("err_oob", 32'(err_oob), 32'(e_err));
    endtask

    task automatic step();
        check("wr_ready", 32'(wr_ready), 32'(model_ready()));
        check("busy", 32'(busy), 32'(model_busy()));
        @(posedge vgaClk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_ready", 32'(wr_ready), 32'(1));
        @(negedge vgaClk);
        rst = 1'b1;
    endtask

    task automatic put(input logic [7:0] idx, input logic [23:0] rgb);
        wr_valid = 1'b1; wr_index = idx; wr_rgb = rgb;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        bit found;
        logic [7:0] idxs [4];
        rst = 1'b0; videoOn = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
        wr_index = 8'h00; wr_rgb = 24'h0;
        model_reset();
        #3;
        do_reset();

        // single write during blanking, one-cycle latency
        put(8'd3, 24'hFF8000);
        check("t1_we", 32'(pal_we), 32'(0));
        step();
        check("t1_commit", {pal_we, 7'd0, pal_addr, pal_wdata[23:8]}, {1'b1, 7'd0, 8'd3, 16'hFF80});
        step();
        check("t1_busy_low", 32'(busy), 32'(0));

        // fill FIFO during active video, drain in order once blanking starts
        videoOn = 1'b1;
        idxs[0] = 8'd0; idxs[1] = 8'd1; idxs[2] = 8'd2; idxs[3] = 8'd5;
        for (int i = 0; i < 4; i++) put(idxs[i], 24'h101010 * (i + 1));
        check("t2_full_ready", 32'(wr_ready), 32'(0));
        step(); step();
        videoOn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_order", {pal_we, 23'd0, pal_addr}, {1'b1, 23'd0, idxs[i]});
        end
        step();

        // out-of-range indices rejected
        put(8'd18, 24'h123456);
        check("t3_err18", 32'(err_oob), 32'(1));
        put(8'd200, 24'h654321);
        check("t3_err200", 32'(err_oob), 32'(1));
        step();
        check("t3_busy", 32'(busy), 32'(0));

        // clear flushes queued writes
        videoOn = 1'b1;
        put(8'd9, 24'hAAAAAA);
        put(8'd10, 24'hBBBBBB);
        clear_req = 1'b1; step(); clear_req = 1'b0;
        videoOn = 1'b0;
        for (int i = 0; i < ENTRIES + 4; i++) step();
        check("t4_done", 32'(busy), 32'(0));

        // clear with videoOn toggling every 5 cycles
        clear_req = 1'b1; step(); clear_req = 1'b0;
        for (int i = 0; i < 5 * 2 * ENTRIES; i++) begin
            videoOn = ((i / 5) % 2) == 1;
            step();
        end
        videoOn = 1'b0;
        step();
        check("t5_done", 32'(busy), 32'(0));

        // reset in the middle of a clear
        clear_req = 1'b1; step(); clear_req = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (pal_we && pal_addr == 8'd7) found = 1;
        end
        check("t6_addr7_reached", 32'(found), 32'(1));
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t6_idle", 32'(busy), 32'(0));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            videoOn   = ($urandom_range(0, 99) < 40);
            wr_valid  = $urandom_range(0, 1) == 1;
            wr_index  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(18, 255))
                                                    : 8'($urandom_range(0, 17));
            wr_rgb    = 24'($urandom);
            clear_req = ($urandom_range(0, 59) == 0);
            step();
        end
        wr_valid = 1'b0; clear_req = 1'b0; videoOn = 1'b0;
        for (int i = 0; i < ENTRIES + 8; i++) step();
        check("rand_drained", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/palette_update_ctrl.md
# palette_update_ctrl

Write scheduler for the display palette RAM that sits between the CPU-side palette write path and the pixel-printer colour lookup. It buffers CPU palette-entry writes in a small FIFO and commits them to the palette RAM only while the display is blanking (`videoOn` low), so no visible line ever shows a half-updated palette. It also runs a full-palette clear sequence that writes black to every entry, again during blanking only.

## Interface
- `ENTRIES`, 18: number of palette entries; valid indices are 0..ENTRIES-1.
- `IDX_W`, 8: colour-index width.
- `DEPTH`, 4: write FIFO depth (power of two).
- `vgaClk`  in  1  pixel clock, sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `videoOn`  in  1  active-video flag from the display timing generator, synchronous to `vgaClk`.
- `wr_valid`  in  1  CPU write request.
- `wr_ready`  out  1  FIFO can accept a write.
- `wr_index`  in  IDX_W  target palette entry.
- `wr_rgb`  in  24  colour value, {R[23:16], G[15:8], B[7:0]}.
- `clear_req`  in  1  single-cycle pulse: flush pending writes, then blacken the whole palette.
- `pal_we`  out  1  palette RAM write enable, registered.
- `pal_addr`  out  IDX_W  palette RAM address, registered.
- `pal_wdata`  out  24  palette RAM data, registered.
- `busy`  out  1  a clear is pending or running, or the FIFO is non-empty.
- `err_oob`  out  1  one-cycle pulse when an out-of-range write is rejected.

## Operation
- States: IDLE and CLEAR. `clear_pend` flag and a FIFO count of 0..DEPTH.
- Accept: a write is taken on an edge where `wr_valid && wr_ready`.
  - If `wr_index < ENTRIES`, the {index, rgb} pair is pushed into the FIFO.
  - Otherwise the write is not pushed and `err_oob` pulses high for the following cycle.
- `wr_ready = !full && !clear_pend && state==IDLE`.
  - `wr_ready` is derived from `full` only. A pop in the same cycle does not open a slot while full.
- Commit (IDLE): on each edge where `videoOn==0`, the FIFO is non-empty and `clear_pend==0`, the FIFO pops its head.
  - On that edge the block registers `pal_we=1`, `pal_addr=index` and `pal_wdata=rgb`.
  - Otherwise it registers `pal_we=0`, and `pal_addr`/`pal_wdata` hold their values.
  - Writes commit in FIFO order. At most one write commits per cycle.
- A simultaneous push and pop leaves the count unchanged.
- `clear_req` sampled high:
  - Sets `clear_pend`, forces the FIFO count to 0 (pending entries are discarded) and discards any push on the same edge.
  - On the next edge the state goes to CLEAR with `cnt=0`.
- CLEAR:
  - On each edge with `videoOn==0`, the block registers `pal_we=1`, `pal_addr=cnt` and `pal_wdata=24'h000000`, then does `cnt++`.
  - While `videoOn==1` the sequence pauses with `pal_we=0` and `cnt` held.
  - The edge that writes `cnt==ENTRIES-1` returns the state to IDLE and clears `clear_pend`.
  - `clear_req` is ignored while a clear is pending or running.
- `busy = clear_pend || state==CLEAR || count!=0`.

## Timing
- Reset (`rst` low, asynchronous) values:
  - `pal_we=0`, `pal_addr=0`, `pal_wdata=0`, `err_oob=0`.
  - FIFO empty, `clear_pend=0`, state IDLE, `cnt=0`.
  - Combinational outputs are therefore `busy=0` and `wr_ready=1`.
- Reset mid-clear or with FIFO entries pending abandons all work. No further `pal_we` is issued.
- Write latency: a write accepted at edge N into an empty FIFO with `videoOn` low gives `pal_we` high after edge N+1. The minimum is 1 cycle. The maximum is unbounded while `videoOn` stays high.
- `videoOn` is sampled at the commit edge only. A commit is never split across its rising edge.
- Clear duration: 1 cycle to enter CLEAR, plus ENTRIES blanking cycles.
- `err_oob` is high for exactly one cycle per rejected write.

## Test plan
- Reset, then `videoOn=0`, write idx 3 / 24'hFF8000 → after the next edge `pal_we=1`, `pal_addr=3`, `pal_wdata=FF8000` for one cycle; `busy` drops to 0.
- `videoOn=1`, push writes to idx 0,1,2,5 → `wr_ready=0` after the 4th push and `pal_we` stays 0; drop `videoOn` → four consecutive `pal_we` pulses at addr 0,1,2,5 in order; `wr_ready` returns to 1 after the first pop.
- Write idx 18 and idx 200 → `err_oob` pulses once for each, no `pal_we`, FIFO count stays 0.
- Push 2 writes with `videoOn=1`, then pulse `clear_req` → FIFO flushed; with `videoOn=0`, `pal_we` pulses at addr 0..17 with data 0; neither queued write ever commits; `wr_ready` low throughout.
- Clear with `videoOn` toggling every 5 cycles → writes occur only in low phases; every address 0..17 is written exactly once, in order.
- Assert `rst` midway through a clear (after addr 7) → outputs return to reset values at once; after release, no further writes occur and `busy=0`.
